// File: rtl/key_switch_io.sv
// key_switch_io
//   Memory-mapped responder for the board keys and switches. KEY[3:0]
//   (active-low) and SW[9:0] are synchronized and debounced per group.
//   Each accepted change sets a sticky ready flag, a second change before
//   that flag is cleared sets overrun, and an interrupt request is raised
//   when ready and interrupt-enable are both set.
//
//   Register map, as byte offsets from BASE; ADDR[0] is ignored:
//     0x0 KDATA  {12'b0, kdeb}                        read-only
//     0x2 SDATA  {6'b0, sdeb}                         read-only
//     0x4 KCTRL  {11'b0, kie, 1'b0, kovr, 1'b0, krdy}
//     0x6 SCTRL  {11'b0, sie, 1'b0, sovr, 1'b0, srdy}
//   A load from a DATA register clears that group's ready flag.
//   A store to a CTRL register sets ie from DIN[4], and clears ovr when DIN[2]=0.
//
// Ports
//   i_clk      system clock
//   i_reset    synchronous active-high reset
//   i_addr     data-bus byte address
//   i_re       read strobe, one cycle per load
//   i_we       write strobe
//   i_din      store data
//   o_dout     read data, combinational, 0 when not selected
//   o_sel      address falls inside BASE..BASE+7, combinational
//   i_key      raw keys, active-low, asynchronous
//   i_sw       raw switches, asynchronous
//   o_irq      registered interrupt request

// Synchronizer plus stability qualifier for one input group.
module key_switch_io_deb #(
   parameter int W          = 4,
   parameter int DEB_CYCLES = 500000,
   parameter int CBITS      = 19
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic [W-1:0] i_raw,
   output logic [W-1:0] o_deb,
   output logic         o_evt
);
   localparam logic [CBITS-1:0] C_TC = CBITS'(DEB_CYCLES - 1);

   logic [W-1:0]     r_sync1;
   logic [W-1:0]     r_sync2;
   logic [W-1:0]     r_cand;
   logic [W-1:0]     r_deb;
   logic [CBITS-1:0] r_cnt;
   logic             w_evt;

   // The event is combinational so that the status flags update on the same
   // edge that loads the new debounced level.
   assign w_evt = (r_sync2 == r_cand) && (r_cnt == C_TC) && (r_cand != r_deb);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_cand  <= '0;
         r_deb   <= '0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
         end else if (w_evt) begin
            r_deb <= r_cand;
         end else if (r_cnt != C_TC) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_deb = r_deb;
   assign o_evt = w_evt;
endmodule

// Sticky ready / overrun / interrupt-enable flags for one input group.
module key_switch_io_stat (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_evt,
   input  logic i_rd_clr,
   input  logic i_wr_ctrl,
   input  logic i_din_ie,
   input  logic i_din_ovr,
   output logic o_rdy,
   output logic o_ovr,
   output logic o_ie
);
   logic r_rdy;
   logic r_ovr;
   logic r_ie;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rdy <= 1'b0;
         r_ovr <= 1'b0;
         r_ie  <= 1'b0;
      end else begin
         // A new event outranks the clearing read.
         if (i_evt)
            r_rdy <= 1'b1;
         else if (i_rd_clr)
            r_rdy <= 1'b0;

         // Setting overrun outranks a CTRL store that would clear it.
         if (i_evt && r_rdy && !i_rd_clr)
            r_ovr <= 1'b1;
         else if (i_wr_ctrl && !i_din_ovr)
            r_ovr <= 1'b0;

         if (i_wr_ctrl)
            r_ie <= i_din_ie;
      end
   end

   assign o_rdy = r_rdy;
   assign o_ovr = r_ovr;
   assign o_ie  = r_ie;
endmodule

module key_switch_io #(
   parameter logic [15:0] BASE       = 16'hFFF0,
   parameter int          DEB_CYCLES = 500000,
   parameter int          CBITS      = 19
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_addr,
   input  logic        i_re,
   input  logic        i_we,
   input  logic [15:0] i_din,
   output logic [15:0] o_dout,
   output logic        o_sel,
   input  logic [3:0]  i_key,
   input  logic [9:0]  i_sw,
   output logic        o_irq
);
   logic [1:0]  w_off;
   logic        w_sel;
   logic        w_rd_k;
   logic        w_rd_s;
   logic        w_wr_k;
   logic        w_wr_s;
   logic [3:0]  w_kdeb;
   logic [9:0]  w_sdeb;
   logic        w_kevt;
   logic        w_sevt;
   logic        w_krdy;
   logic        w_kovr;
   logic        w_kie;
   logic        w_srdy;
   logic        w_sovr;
   logic        w_sie;
   logic [15:0] w_dout;
   logic        r_irq;
   logic        w_unused;

   assign w_sel = (i_addr[15:3] == BASE[15:3]);
   assign w_off = i_addr[2:1];

   assign w_rd_k = i_re & w_sel & (w_off == 2'd0);
   assign w_rd_s = i_re & w_sel & (w_off == 2'd1);
   assign w_wr_k = i_we & w_sel & (w_off == 2'd2);
   assign w_wr_s = i_we & w_sel & (w_off == 2'd3);

   // Keys are inverted ahead of the synchronizer so both groups idle at 0
   // and the debounced key value reads 1 for a pressed key.
   key_switch_io_deb #(.W(4), .DEB_CYCLES(DEB_CYCLES), .CBITS(CBITS)) u_kdeb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_raw   (~i_key),
      .o_deb   (w_kdeb),
      .o_evt   (w_kevt)
   );

   key_switch_io_deb #(.W(10), .DEB_CYCLES(DEB_CYCLES), .CBITS(CBITS)) u_sdeb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_raw   (i_sw),
      .o_deb   (w_sdeb),
      .o_evt   (w_sevt)
   );

   key_switch_io_stat u_kstat (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_evt     (w_kevt),
      .i_rd_clr  (w_rd_k),
      .i_wr_ctrl (w_wr_k),
      .i_din_ie  (i_din[4]),
      .i_din_ovr (i_din[2]),
      .o_rdy     (w_krdy),
      .o_ovr     (w_kovr),
      .o_ie      (w_kie)
   );

   key_switch_io_stat u_sstat (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_evt     (w_sevt),
      .i_rd_clr  (w_rd_s),
      .i_wr_ctrl (w_wr_s),
      .i_din_ie  (i_din[4]),
      .i_din_ovr (i_din[2]),
      .o_rdy     (w_srdy),
      .o_ovr     (w_sovr),
      .o_ie      (w_sie)
   );

   always_comb begin
      w_dout = 16'h0000;
      if (w_sel) begin
         case (w_off)
            2'd0:    w_dout = {12'b0, w_kdeb};
            2'd1:    w_dout = {6'b0, w_sdeb};
            2'd2:    w_dout = {11'b0, w_kie, 1'b0, w_kovr, 1'b0, w_krdy};
            default: w_dout = {11'b0, w_sie, 1'b0, w_sovr, 1'b0, w_srdy};
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_irq <= 1'b0;
      else
         r_irq <= (w_krdy & w_kie) | (w_srdy & w_sie);
   end

   // Address bit 0 and the store-data bits outside the CTRL fields have no function.
   assign w_unused = ^{i_addr[0], i_din[15:5], i_din[3], i_din[1:0]};

   assign o_dout = w_dout;
   assign o_sel  = w_sel;
   assign o_irq  = r_irq;
endmodule

// File: tb/tb_key_switch_io.sv
module tb_key_switch_io;
   localparam int DEB = 4;

   localparam logic [15:0] A_KDATA = 16'hFFF0;
   localparam logic [15:0] A_SDATA = 16'hFFF2;
   localparam logic [15:0] A_KCTRL = 16'hFFF4;
   localparam logic [15:0] A_SCTRL = 16'hFFF6;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [15:0] i_addr;
   logic        i_re;
   logic        i_we;
   logic [15:0] i_din;
   logic [15:0] o_dout;
   logic        o_sel;
   logic [3:0]  i_key;
   logic [9:0]  i_sw;
   logic        o_irq;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      string       name;
      logic        sel;
      logic [15:0] dout;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [15:0] addr;
      logic        re;
      logic        we;
      logic [15:0] din;
      logic        sel;
      logic [15:0] dout;
   } vec_t;
   vec_t vt[13];

   key_switch_io #(.BASE(16'hFFF0), .DEB_CYCLES(DEB), .CBITS(3)) dut (
      .i_clk   (clk),
      .i_reset (i_reset),
      .i_addr  (i_addr),
      .i_re    (i_re),
      .i_we    (i_we),
      .i_din   (i_din),
      .o_dout  (o_dout),
      .o_sel   (o_sel),
      .i_key   (i_key),
      .i_sw    (i_sw),
      .o_irq   (o_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected bus responses are queued when the access is driven and
   // compared on the falling edge, mid-cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_t e;
         e = sb_q.pop_front();
         check(e.name, {o_sel, o_dout}, {e.sel, e.dout});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic access(input logic [15:0] a, input logic re, input logic we,
                         input logic [15:0] d, input string nm,
                         input logic exp_sel, input logic [15:0] exp_dout);
      i_addr = a;
      i_re   = re;
      i_we   = we;
      i_din  = d;
      sb_q.push_back('{nm, exp_sel, exp_dout});
      @(posedge clk);
      #1;
      i_re = 1'b0;
      i_we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic re, input string nm, input logic [15:0] exp);
      access(a, re, 1'b0, 16'h0000, nm, 1'b1, exp);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      i_addr = a;
      i_we   = 1'b1;
      i_din  = d;
      @(posedge clk);
      #1;
      i_we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // State at the point the table runs: KDATA=9, KCTRL=krdy, S group idle.
      vt[0]  = '{16'hFFF0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0009};
      vt[1]  = '{16'hFFF1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0009};
      vt[2]  = '{16'hFFF4, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001};
      vt[3]  = '{16'hFFF5, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001};
      vt[4]  = '{16'hFFF2, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
      vt[5]  = '{16'hFFF7, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
      vt[6]  = '{16'hFFEE, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000};
      vt[7]  = '{16'hFFF8, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000};
      vt[8]  = '{16'hFFFC, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000};
      vt[9]  = '{16'h0004, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000};
      vt[10] = '{16'hFFF4, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001};
      vt[11] = '{16'hFFF0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0009};
      vt[12] = '{16'hFFF4, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};

      i_reset = 1'b1;
      i_addr  = 16'h0000;
      i_re    = 1'b0;
      i_we    = 1'b0;
      i_din   = 16'h0000;
      i_key   = 4'hF;
      i_sw    = 10'h000;
      @(posedge clk);
      tick(1);
      i_reset = 1'b0;

      // reset state
      rd(A_KDATA, 1'b0, "rst_kdata", 16'h0000);
      rd(A_SDATA, 1'b0, "rst_sdata", 16'h0000);
      rd(A_KCTRL, 1'b0, "rst_kctrl", 16'h0000);
      rd(A_SCTRL, 1'b0, "rst_sctrl", 16'h0000);
      check("rst_irq", {16'h0, o_irq}, 17'h0);

      // key 0 pressed: visible after exactly DEB+3 sampling edges
      i_key = 4'b1110;
      for (int k = 0; k < DEB + 4; k++)
         rd(A_KDATA, 1'b0, $sformatf("klat_%0d", k), (k == DEB + 3) ? 16'h0001 : 16'h0000);
      rd(A_KCTRL, 1'b0, "klat_kctrl", 16'h0001);
      rd(16'hFFF1, 1'b0, "addr0_ignored", 16'h0001);
      rd(A_KDATA, 1'b1, "kdata_clr_rd", 16'h0001);
      rd(A_KCTRL, 1'b0, "kctrl_cleared", 16'h0000);

      // 3-cycle glitch on key 1 is rejected
      i_key = 4'b1100;
      tick(DEB - 1);
      i_key = 4'b1110;
      tick(10);
      rd(A_KDATA, 1'b0, "glitch_kdata", 16'h0001);
      rd(A_KCTRL, 1'b0, "glitch_kctrl", 16'h0000);

      // key 1 held long enough is accepted
      i_key = 4'b1100;
      tick(8);
      rd(A_KDATA, 1'b0, "hold_kdata", 16'h0003);
      rd(A_KCTRL, 1'b0, "hold_kctrl", 16'h0001);

      // second change without a read -> overrun
      i_key = 4'b1110;
      tick(8);
      rd(A_KCTRL, 1'b0, "ovr_kctrl", 16'h0005);
      rd(A_KDATA, 1'b1, "ovr_kdata_rd", 16'h0001);
      rd(A_KCTRL, 1'b0, "ovr_after_rd", 16'h0004);
      wr(A_KDATA, 16'hFFFF);
      wr(A_KCTRL, 16'h0004);
      rd(A_KCTRL, 1'b0, "ovr_wr1_keeps", 16'h0004);
      rd(A_KDATA, 1'b0, "kdata_wr_ignored", 16'h0001);
      wr(A_KCTRL, 16'h0000);
      rd(A_KCTRL, 1'b0, "ovr_wr0_clears", 16'h0000);

      // switch group with interrupt enabled
      wr(A_SCTRL, 16'h0010);
      i_sw = 10'h3FF;
      for (int k = 0; k < DEB + 4; k++) begin
         rd(A_SCTRL, 1'b0, $sformatf("slat_%0d", k), (k == DEB + 3) ? 16'h0011 : 16'h0010);
         check($sformatf("irq_rise_%0d", k), {16'h0, o_irq}, {16'h0, (k == DEB + 3)});
      end
      rd(A_SDATA, 1'b0, "sdata_3ff", 16'h03FF);
      rd(A_SDATA, 1'b1, "sdata_clr_rd", 16'h03FF);
      check("irq_lag", {16'h0, o_irq}, 17'h1);
      tick(1);
      check("irq_fall", {16'h0, o_irq}, 17'h0);
      rd(A_SCTRL, 1'b0, "sctrl_after_rd", 16'h0010);

      // event coinciding with a clearing read: rdy stays, no overrun
      i_sw = 10'h000;
      tick(10);
      rd(A_SCTRL, 1'b0, "sctrl_rdy_again", 16'h0011);
      i_sw = 10'h3FF;
      tick(DEB + 2);
      rd(A_SDATA, 1'b1, "evt_rd_same", 16'h0000);
      rd(A_SCTRL, 1'b0, "evt_rd_sctrl", 16'h0011);
      rd(A_SDATA, 1'b0, "evt_rd_sdata", 16'h03FF);

      // event coinciding with an ovr-clearing CTRL store: set wins
      i_sw = 10'h000;
      tick(DEB + 2);
      wr(A_SCTRL, 16'h0010);
      rd(A_SCTRL, 1'b0, "evt_wr_sctrl", 16'h0015);
      wr(A_SCTRL, 16'h0000);
      rd(A_SCTRL, 1'b0, "sctrl_wr0", 16'h0001);
      rd(A_SDATA, 1'b1, "sdata_rd0", 16'h0000);
      rd(A_SCTRL, 1'b0, "sctrl_idle", 16'h0000);

      // reset mid-debounce (cnt=2) with key held through it
      wr(A_KCTRL, 16'h0010);
      i_key = 4'b0110;
      tick(DEB + 1);
      i_reset = 1'b1;
      tick(1);
      i_reset = 1'b0;
      check("rst2_irq", {16'h0, o_irq}, 17'h0);
      for (int k = 0; k < DEB + 4; k++)
         rd(A_KDATA, 1'b0, $sformatf("rst2_lat_%0d", k), (k == DEB + 3) ? 16'h0009 : 16'h0000);
      rd(A_KCTRL, 1'b0, "rst2_kctrl", 16'h0001);
      rd(A_SCTRL, 1'b0, "rst2_sctrl", 16'h0000);

      // address decode table
      for (int i = 0; i < 13; i++)
         access(vt[i].addr, vt[i].re, vt[i].we, vt[i].din, $sformatf("tbl_%0d", i),
                vt[i].sel, vt[i].dout);

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
